// File: rtl/video_pkg.sv
// Shared stream-video definitions: sync polarities, crop FSM states, coordinate width helper.
package video_pkg;

  localparam logic HS_BLANK  = 1'b1;  // hs level during horizontal blanking
  localparam logic VS_ACTIVE = 1'b1;  // vs level while a frame is active

  typedef enum logic [1:0] {S_WAIT_LOW, S_WAIT_FRAME, S_ACTIVE} crop_state_t;

  function automatic int coord_width(input int line_size_max);
    return $clog2(line_size_max);
  endfunction

endpackage

// File: rtl/video_sync_edge.sv
// Registers hs/vs and flags end-of-line (hs rise) and frame start/end (vs rise/fall).
module video_sync_edge
  import video_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_hs,
  input  logic i_vs,
  output logic o_hs_rise,
  output logic o_vs_rise,
  output logic o_vs_fall
);

  logic r_hs, r_vs;

  // Idle levels on reset so a released reset never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs <= HS_BLANK;
      r_vs <= ~VS_ACTIVE;
    end else begin
      r_hs <= i_hs;
      r_vs <= i_vs;
    end
  end

  assign o_hs_rise = (i_hs == HS_BLANK) && (r_hs != HS_BLANK);
  assign o_vs_rise = (i_vs == VS_ACTIVE) && (r_vs != VS_ACTIVE);
  assign o_vs_fall = (i_vs != VS_ACTIVE) && (r_vs == VS_ACTIVE);

endmodule

// File: rtl/video_crop.sv
// ROI cropper on the di/de/hs/vs stream, 1-clk latency on every output.
// Optional window statistics ports enabled by macro VIDEO_CROP_STAT_EN.
module video_crop
  import video_pkg::*;
#(
  parameter  int PIXEL_WIDTH   = 8,
  parameter  int LINE_SIZE_MAX = 4096,
  localparam int CW            = coord_width(LINE_SIZE_MAX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bypass,
  input  logic [CW-1:0]          x_start,
  input  logic [CW-1:0]          y_start,
  input  logic [CW-1:0]          win_w,
  input  logic [CW-1:0]          win_h,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
`ifdef VIDEO_CROP_STAT_EN
  ,
  input  logic                   stat_clr_i,
  output logic [CW:0]            stat_w_o,
  output logic [CW:0]            stat_h_o
`endif
);

  localparam logic [CW-1:0] XY_MAX = CW'(LINE_SIZE_MAX - 1);

  crop_state_t   r_state, w_state_nxt;
  logic          w_hs_rise, w_vs_rise, w_vs_fall, w_frame_start;
  logic          w_active, w_row_in, w_col_in, w_de_nxt, w_hs_nxt, w_do_en;
  logic [CW-1:0] r_x, r_y, r_xs, r_ys, r_ww, r_wh;
  logic [CW:0]   w_x_end, w_y_end;

  video_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_hs      (hs_i),
    .i_vs      (vs_i),
    .o_hs_rise (w_hs_rise),
    .o_vs_rise (w_vs_rise),
    .o_vs_fall (w_vs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_WAIT_LOW;
    else      r_state <= w_state_nxt;
  end

  // WAIT_LOW keeps a frame already running at reset release from being cropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_LOW:   if (vs_i != VS_ACTIVE) w_state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: if (w_vs_rise)         w_state_nxt = S_ACTIVE;
      S_ACTIVE:     if (w_vs_fall)         w_state_nxt = S_WAIT_FRAME;
      default:                             w_state_nxt = S_WAIT_LOW;
    endcase
  end

  assign w_frame_start = (r_state == S_WAIT_FRAME) && w_vs_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xs <= '0; r_ys <= '0; r_ww <= '0; r_wh <= '0;
    end else if (w_frame_start) begin
      r_xs <= x_start; r_ys <= y_start; r_ww <= win_w; r_wh <= win_h;
    end
  end

  // A pixel on the hs-rise cycle was already tested against the ending line's x.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_frame_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_hs_rise) begin
      r_x <= '0;
      if (r_y != XY_MAX) r_y <= r_y + 1'b1;
    end else if (de_i && (r_x != XY_MAX)) begin
      r_x <= r_x + 1'b1;
    end
  end

  assign w_x_end  = {1'b0, r_xs} + {1'b0, r_ww};
  assign w_y_end  = {1'b0, r_ys} + {1'b0, r_wh};
  assign w_row_in = (r_y >= r_ys) && ({1'b0, r_y} < w_y_end);
  assign w_col_in = (r_x >= r_xs) && ({1'b0, r_x} < w_x_end);

  always_comb begin
    w_active = (r_state == S_ACTIVE);
    w_de_nxt = 1'b0;
    w_hs_nxt = HS_BLANK;
    if (bypass) begin
      w_de_nxt = de_i;
      w_hs_nxt = hs_i;
    end else if (w_active) begin
      w_de_nxt = de_i & w_row_in & w_col_in;
      w_hs_nxt = hs_i | ~w_row_in;
    end
    w_do_en = bypass | w_de_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= HS_BLANK;
      vs_o <= ~VS_ACTIVE;
    end else begin
      de_o <= w_de_nxt;
      hs_o <= w_hs_nxt;
      vs_o <= vs_i;
      if (w_do_en) do_o <= di_i;
    end
  end

`ifdef VIDEO_CROP_STAT_EN
  logic [CW:0] r_cur_w, r_last_w, r_lines, w_cur_nxt;
  logic        w_vs_o_fall, w_cur_any;

  assign w_cur_nxt   = r_cur_w + {{CW{1'b0}}, w_de_nxt};
  assign w_cur_any   = (w_cur_nxt != '0);
  assign w_vs_o_fall = (vs_o == VS_ACTIVE) && (vs_i != VS_ACTIVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || 1'b0) begin
      r_cur_w <= '0; r_last_w <= '0; r_lines <= '0;
    end else if (w_frame_start) begin
      r_cur_w <= '0; r_last_w <= '0; r_lines <= '0;
    end else if (w_hs_rise) begin
      r_cur_w <= '0;
      if (w_cur_any) begin
        r_last_w <= w_cur_nxt;
        r_lines  <= r_lines + 1'b1;
      end
    end else begin
      r_cur_w <= w_cur_nxt;
    end
  end

  // A line still open when vs drops counts as finished.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_w_o <= '0;
      stat_h_o <= '0;
    end else if (stat_clr_i) begin
      stat_w_o <= '0;
      stat_h_o <= '0;
    end else if (w_vs_o_fall) begin
      stat_w_o <= w_cur_any ? w_cur_nxt : r_last_w;
      stat_h_o <= r_lines + {{CW{1'b0}}, w_cur_any};
    end
  end
`endif

endmodule
